// File: rtl/instr_mem_loader_if.sv
// Bus between the program-load UART side / CPU fetch and the loader.
// The slave modport is the loader's view; master is the driver's view.
interface instr_mem_loader_if #(
   parameter int NBITS = 32
);
   logic             i_start;
   logic [7:0]       i_rx_data;
   logic             i_rx_done;
   logic [NBITS-1:0] i_PC;
   logic [NBITS-1:0] o_mem_addr;
   logic [NBITS-1:0] o_mem_wdata;
   logic             o_mem_we;
   logic             o_cpu_stall;
   logic             o_done;
   logic             o_error;

   modport master (
      output i_start, i_rx_data, i_rx_done, i_PC,
      input  o_mem_addr, o_mem_wdata, o_mem_we,
      input  o_cpu_stall, o_done, o_error
   );

   modport slave (
      input  i_start, i_rx_data, i_rx_done, i_PC,
      output o_mem_addr, o_mem_wdata, o_mem_we,
      output o_cpu_stall, o_done, o_error
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Assembles received bytes MSB-first into words and writes them to
// instruction memory, stalling the CPU until a HALT word or overflow.
module instr_mem_loader #(
   parameter int NBITS  = 32,
   parameter int CELDAS = 60
) (
   input logic               i_clk,
   input logic               i_reset,
   instr_mem_loader_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } state_t;

   localparam logic [NBITS:0] LAST = (NBITS+1)'(CELDAS - 4);

   state_t           state, state_n;
   logic [NBITS-1:0] addr_q, addr_n;
   logic [NBITS-1:0] word_q, word_n;
   logic [NBITS-1:0] word_sh;
   logic [1:0]       cnt_q, cnt_n;
   logic             err_q, err_n;
   logic [NBITS:0]   addr_inc;
   logic             stall;

   assign word_sh  = {word_q[NBITS-9:0], bus.i_rx_data};
   // one extra bit so the overflow compare cannot wrap
   assign addr_inc = {1'b0, addr_q} + (NBITS+1)'(4);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state  <= IDLE;
         addr_q <= '0;
         word_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_n;
         addr_q <= addr_n;
         word_q <= word_n;
         cnt_q  <= cnt_n;
         err_q  <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      addr_n  = addr_q;
      word_n  = word_q;
      cnt_n   = cnt_q;
      err_n   = err_q;
      unique case (state)
         IDLE: begin
            if (bus.i_start) begin
               state_n = RECV;
               addr_n  = '0;
               cnt_n   = '0;
            end
         end
         RECV: begin
            if (bus.i_rx_done) begin
               word_n = word_sh;
               if (cnt_q == 2'd3) begin
                  cnt_n   = '0;
                  state_n = WRITE;
               end else begin
                  cnt_n = cnt_q + 2'd1;
               end
            end
         end
         WRITE: begin
            if (&word_q) begin
               state_n = DONE;
            end else if (addr_inc > LAST) begin
               state_n = DONE;
               err_n   = 1'b1;
            end else begin
               state_n = RECV;
               addr_n  = addr_inc[NBITS-1:0];
               // a byte landing during the write starts the next word
               if (bus.i_rx_done) begin
                  word_n = word_sh;
                  cnt_n  = 2'd1;
               end else begin
                  cnt_n = '0;
               end
            end
         end
         DONE: begin
            if (bus.i_start) begin
               state_n = RECV;
               addr_n  = '0;
               cnt_n   = '0;
               err_n   = 1'b0;
            end
         end
      endcase
   end

   assign stall           = (state == RECV) || (state == WRITE);
   assign bus.o_cpu_stall = stall;
   assign bus.o_mem_addr  = stall ? addr_q : bus.i_PC;
   assign bus.o_mem_wdata = word_q;
   assign bus.o_mem_we    = (state == WRITE) && !i_reset;
   assign bus.o_done      = (state == DONE);
   assign bus.o_error     = err_q;
endmodule
